fetch_stage: RTL and testbench

- Instruction fetch stage. Issues in-order requests to instruction memory, buffers returned words with their PCs in a small prefetch FIFO, and drives the fetch/decode pipeline register (pcD, instrD, validD) consumed by the decode stage.
- Handles decode back-pressure (stall), control-flow redirects from execute, and halt on finish.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_stage.sv | 161 ++++++++++++++++
 tb/tb_fetch_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch stage.
//   - fetch_entry_t : one prefetched instruction together with its PC
//   - NOP_INSTR     : instruction placed in instrD when no live instruction
//   - cnt_width()   : width of a counter that must hold 0..max_val
//   Provides a fallback for the global `WORD define when the global defines
//   file is not part of the compile.
// -----------------------------------------------------------------------------
`ifndef WORD
`define WORD [31:0]
`endif

package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous prefetch FIFO of fetch_entry_t. Flush has priority over push
//   and pop. Head entry is presented combinationally on rdata.
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   push, wdata      write an entry (ignored when full)
//   pop, rdata       remove the head entry (ignored when empty) / head entry
//   flush            discard all entries
//   count            current number of entries
//   empty, full      status flags
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  fetch_entry_t                   wdata,
  input  logic                           pop,
  output fetch_entry_t                   rdata,
  input  logic                           flush,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; entries are only observed between a push and
  // its pop, so resetting the array would cost flops for no behaviour.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch: issues in-order requests to instruction memory under a
//   credit limit, buffers returned words with their PCs in a prefetch FIFO and
//   drives the fetch/decode pipeline register (pcD, instrD, validD).
//   Redirects flush the FIFO and discard responses still in flight; haltF
//   stops new requests while in-flight work drains to decode.
// Optional build macro:
//   FETCH_BYPASS_EN  a live response arriving while the FIFO is empty and
//                    decode is accepting loads pcD/instrD directly.
// Ports:
//   clk, reset                   clock, synchronous active-low reset
//   imemReq, imemAddr, imemGnt   request handshake to instruction memory
//   imemRvalid, imemRdata        in-order responses
//   redirect, redirectPc         control-flow change from execute
//   stallD                       decode back-pressure
//   haltF                        suppress new requests
//   pcD, instrD, validD          fetch/decode pipeline register
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUTST  = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       imemReq,
  output logic `WORD imemAddr,
  input  logic       imemGnt,
  input  logic       imemRvalid,
  input  logic `WORD imemRdata,
  input  logic       redirect,
  input  logic `WORD redirectPc,
  input  logic       stallD,
  input  logic       haltF,
  output logic `WORD pcD,
  output logic `WORD instrD,
  output logic       validD
);

  localparam int OW = cnt_width(MAX_OUTST);
  localparam int CW = cnt_width(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outst_next;
  logic [OW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  fetch_entry_t  fifo_head;
  fetch_entry_t  resp_entry;
  logic          credit_ok;
  logic          accept;
  logic          resp_live;
  logic          bypass;
  logic          push;
  logic          pop;

  // Every request reserves a FIFO slot up front, so a response always has
  // room even when decode is stalled. A same-cycle pop is not credited.
  assign credit_ok = (32'(outstanding) < MAX_OUTST) &&
                     (32'(outstanding) + 32'(fifo_count) < FIFO_DEPTH);

  assign imemAddr  = fetch_pc;
  assign imemReq   = reset && !haltF && !redirect && credit_ok;
  assign accept    = imemReq && imemGnt;

  // A response in the redirect cycle is stale by definition.
  assign resp_live = imemRvalid && (discard == '0) && !redirect;

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_live && fifo_empty && !stallD;
`else
  assign bypass = 1'b0;
`endif

  assign push       = resp_live && !bypass;
  assign pop        = !redirect && !stallD && !fifo_empty;
  assign resp_entry = '{pc: resp_pc, instr: imemRdata};

  // NOTE: combinational blocks assign a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    outst_next = outstanding;
    if (accept && !imemRvalid)      outst_next = outstanding + OW'(1);
    else if (!accept && imemRvalid) outst_next = outstanding - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outst_next;
      if (redirect) begin
        fetch_pc <= redirectPc;
        resp_pc  <= redirectPc;
        // Everything still in flight after this cycle belongs to the old path.
        discard  <= outst_next;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (imemRvalid) begin
          if (discard != '0) discard <= discard - OW'(1);
          else               resp_pc <= resp_pc + 32'd4;
        end
      end
    end
  end

  // Fetch/decode pipeline register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pcD    <= '0;
      instrD <= NOP_INSTR;
      validD <= 1'b0;
    end else if (redirect) begin
      instrD <= NOP_INSTR;
      validD <= 1'b0;
    end else if (!stallD) begin
      if (!fifo_empty) begin
        pcD    <= fifo_head.pc;
        instrD <= fifo_head.instr;
        validD <= 1'b1;
      end else if (bypass) begin
        pcD    <= resp_pc;
        instrD <= imemRdata;
        validD <= 1'b1;
      end else begin
        validD <= 1'b0;
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (resp_entry),
    .pop   (pop),
    .rdata (fifo_head),
    .flush (redirect),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Interface contract checks.
  a_rvalid_outst: assert property (@(posedge clk) disable iff (!reset)
    imemRvalid |-> (outstanding != '0));
  a_redirect_align: assert property (@(posedge clk) disable iff (!reset)
    redirect |-> (redirectPc[1:0] == 2'b00));
  a_fifo_room: assert property (@(posedge clk) disable iff (!reset)
    push |-> !fifo_full);

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Scoreboard bench for fetch_stage. The memory model answers granted
//   addresses in order with word = f(addr). Every grant pushes the expected
//   {pc, instr} into a queue; a redirect or reset squashes the queue, since
//   nothing fetched before it may reach decode. A monitor on the falling
//   edge pops and compares whenever the register loads a new instruction.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 4;
  localparam int          MAX_OUTST  = 2;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_LAT = 2;
`else
  localparam int FIRST_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        stallD;
  logic        haltF;
  logic [31:0] pcD;
  logic [31:0] instrD;
  logic        validD;

  fetch_stage #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_OUTST  (MAX_OUTST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemGnt    (imemGnt),
    .imemRvalid (imemRvalid),
    .imemRdata  (imemRdata),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .stallD     (stallD),
    .haltF      (haltF),
    .pcD        (pcD),
    .instrD     (instrD),
    .validD     (validD)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 4) | 32'h13;
  endfunction

  fetch_entry_t exp_q[$];    // instructions decode must still see, in order
  logic [31:0]  mem_q[$];    // addresses granted but not yet answered
  logic [31:0]  exp_fetch = RESET_PC;
  int           gnt_pct   = 100;
  int           rsp_pct   = 100;
  int           cyc       = 0;
  int           first_gnt = -1;
  int           first_valid = -1;
  int           delivered = 0;
  logic         rst_prev = 1'b0, redir_prev = 1'b0, stall_prev = 1'b0;
  logic [31:0]  pcD_prev, instrD_prev;
  logic         validD_prev;

  // Memory model: grants randomly, answers oldest request at least one cycle
  // after its grant.
  always @(posedge clk) begin
    logic [31:0] a;
    #2;
    imemGnt = ($urandom_range(99) < gnt_pct);
    if (reset && mem_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
      a          = mem_q.pop_front();
      imemRvalid = 1'b1;
      imemRdata  = mem_word(a);
    end else begin
      imemRvalid = 1'b0;
      imemRdata  = $urandom;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    fetch_entry_t e;
    cyc++;
    // Result of the edge that just passed.
    if (rst_prev) begin
      check("reset_validD", validD, 0);
      check("reset_instrD", instrD, NOP_INSTR);
      check("reset_pcD", pcD, 0);
    end else if (redir_prev) begin
      check("redir_validD", validD, 0);
      check("redir_instrD", instrD, NOP_INSTR);
      check("redir_pcD_hold", pcD, pcD_prev);
    end else if (stall_prev) begin
      check("stall_pcD", pcD, pcD_prev);
      check("stall_instrD", instrD, instrD_prev);
      check("stall_validD", validD, validD_prev);
    end else if (validD) begin
      if (exp_q.size() == 0) begin
        check("extra_instr", validD, 0);
      end else begin
        e = exp_q.pop_front();
        check("pcD", pcD, e.pc);
        check("instrD", instrD, e.instr);
        delivered++;
        if (first_valid < 0 && first_gnt >= 0) first_valid = cyc;
      end
    end

    // Events of the current cycle, taking effect at the next edge.
    if (!reset) begin
      check("req_in_reset", imemReq, 0);
      exp_q.delete();
      mem_q.delete();
      exp_fetch   = RESET_PC;
      first_gnt   = -1;
      first_valid = -1;
    end else begin
      if (haltF || redirect)
        check("req_blocked", imemReq, 0);
      if (mem_q.size() + int'(imemRvalid) >= MAX_OUTST || exp_q.size() >= FIFO_DEPTH)
        check("req_credit", imemReq, 0);
      else if (!haltF && !redirect && mem_q.size() == 0 && !imemRvalid && exp_q.size() == 0)
        check("req_idle", imemReq, 1);
      if (imemReq && imemGnt) begin
        check("imemAddr", imemAddr, exp_fetch);
        exp_q.push_back('{pc: exp_fetch, instr: mem_word(exp_fetch)});
        mem_q.push_back(imemAddr);
        exp_fetch = exp_fetch + 32'd4;
        if (first_gnt < 0) first_gnt = cyc;
      end
      if (redirect) begin
        exp_q.delete();
        exp_fetch = redirectPc;
      end
    end
    rst_prev    = !reset;
    redir_prev  = reset && redirect;
    stall_prev  = reset && stallD && !redirect;
    pcD_prev    = pcD;
    instrD_prev = instrD;
    validD_prev = validD;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect   = 1'b1;
    redirectPc = target;
    tick(1);
    redirect   = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int          waited;
    reset = 1'b0; redirect = 1'b0; redirectPc = '0; stallD = 1'b0; haltF = 1'b0;
    imemGnt = 1'b0; imemRvalid = 1'b0; imemRdata = '0;
    tick(3);
    reset = 1'b1;

    // Steady stream: first-instruction latency and sequential PCs.
    tick(20);
    check("first_latency", 32'(first_valid - first_gnt), 32'(FIRST_LAT));

    // Decode stall mid-stream.
    stallD = 1'b1;
    tick(5);
    stallD = 1'b0;
    tick(10);

    // Redirect with two requests in flight, answered over the next cycles.
    rsp_pct = 0;
    tick(4);
    do_redirect(32'h0000_0100);
    rsp_pct = 100;
    tick(12);

    // Redirect in the same cycle as a response.
    rsp_pct = 0;
    tick(3);
    rsp_pct = 100;
    do_redirect(32'h0000_0200);
    tick(12);

    // Halt with work in flight, redirect while halted, release.
    haltF = 1'b1;
    tick(8);
    do_redirect(32'h0000_0300);
    tick(3);
    haltF = 1'b0;
    tick(12);

    // Reset mid-stream, then the latency again from reset.
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(15);
    check("first_latency_after_reset", 32'(first_valid - first_gnt), 32'(FIRST_LAT));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      gnt_pct  = 60;
      rsp_pct  = 60;
      stallD   = ($urandom_range(99) < 20);
      if ($urandom_range(99) < 2) haltF = ~haltF;
      if ($urandom_range(99) < 3) begin
        r = $urandom;
        r = r & 32'hFFFF_FFFC;
        if ($urandom_range(3) == 0) r = 32'hFFFF_FFF0;
        redirect   = 1'b1;
        redirectPc = r;
      end else begin
        redirect = 1'b0;
      end
      tick(1);
    end

    // Drain: no new requests, everything in flight must reach decode.
    redirect = 1'b0;
    stallD   = 1'b0;
    haltF    = 1'b1;
    rsp_pct  = 100;
    waited   = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && waited < 50) begin
      tick(1);
      waited++;
    end
    tick(2);
    check("drain_empty", 32'(exp_q.size()), 0);
    check("progress", 32'(delivered > 200), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
